// File: rtl/fetch_queue.sv
// fetch_queue_pkg: packet carried from fetch to issue.
// fetch_queue: circular instruction buffer between fetch and issue.
//   clk, reset (sync, active-high), flush (misprediction, same effect as reset)
//   enq_valid/enq_data in, full out       : fetch side
//   deq_ready in, deq_valid/deq_data out  : issue side, program order
//   count out                             : occupied entries, 0..DEPTH
package fetch_queue_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } pipe_in_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       enq_valid,
    input  pipe_in_t                   enq_data,
    output logic                       full,
    input  logic                       deq_ready,
    output logic                       deq_valid,
    output pipe_in_t                   deq_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pipe_in_t           mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic               clear;
    logic               enq_fire;
    logic               deq_fire;

    // Outputs depend only on registered state.
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign deq_valid = (count_q != CNT_W'(0));
    assign deq_data  = deq_valid ? mem[head] : '0;

    // Enqueue looks only at full, never at deq_ready, so no issue-to-fetch path.
    assign clear    = reset | flush;
    assign enq_fire = enq_valid & ~full;
    assign deq_fire = deq_ready & deq_valid;

    // Pointers and occupancy; power-of-two DEPTH lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (clear) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) tail <= tail + PTR_W'(1);
            if (deq_fire) head <= head + PTR_W'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never cleared; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (enq_fire && !clear) mem[tail] <= enq_data;
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NVEC  = 22;

    logic           clk = 1'b0;
    logic           reset, flush, enq_valid, deq_ready;
    pipe_in_t       enq_data;
    logic           full, deq_valid;
    pipe_in_t       deq_data;
    logic [2:0]     count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .full      (full),
        .deq_ready (deq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .count     (count)
    );

    typedef struct {
        bit          rst;
        bit          fl;
        bit          ev;
        logic [31:0] pc;
        bit          dr;
        int          e_count;
        bit          e_full;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs [NVEC];

    // Packet contents derived from pc so the whole head packet can be checked.
    function automatic pipe_in_t mk(input logic [31:0] pc);
        pipe_in_t p;
        p.pc          = pc;
        p.instr       = 32'h1300_0013 ^ pc;
        p.pred_taken  = pc[2];
        p.pred_target = pc + 32'h100;
        return p;
    endfunction

    task automatic drive(input bit rst, input bit fl, input bit ev,
                         input logic [31:0] pc, input bit dr);
        reset     = rst;
        flush     = fl;
        enq_valid = ev;
        enq_data  = mk(pc);
        deq_ready = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int e_count, input bit e_full,
                         input bit e_valid, input logic [31:0] e_pc);
        pipe_in_t exp_data;
        exp_data = e_valid ? mk(e_pc) : '0;
        tests_run++;
        if (int'(count) != e_count) begin
            tests_failed++;
            $display("FAIL %s count: got %0d want %0d", name, count, e_count);
        end
        tests_run++;
        if (full != e_full) begin
            tests_failed++;
            $display("FAIL %s full: got %0b want %0b", name, full, e_full);
        end
        tests_run++;
        if (deq_valid != e_valid) begin
            tests_failed++;
            $display("FAIL %s deq_valid: got %0b want %0b", name, deq_valid, e_valid);
        end
        tests_run++;
        if (deq_data != exp_data) begin
            tests_failed++;
            $display("FAIL %s deq_data: got pc=%h data=%h want pc=%h data=%h",
                     name, deq_data.pc, deq_data, exp_data.pc, exp_data);
        end
    endtask

    initial begin
        //             rst fl ev pc       dr  cnt full vld pc
        vecs[0]  = '{1, 0, 0, 32'h00, 0,  0, 0, 0, 32'h00};
        vecs[1]  = '{1, 0, 1, 32'h99, 0,  0, 0, 0, 32'h00};
        // fill to full, 5th rejected
        vecs[2]  = '{0, 0, 1, 32'h00, 0,  1, 0, 1, 32'h00};
        vecs[3]  = '{0, 0, 1, 32'h04, 0,  2, 0, 1, 32'h00};
        vecs[4]  = '{0, 0, 1, 32'h08, 0,  3, 0, 1, 32'h00};
        vecs[5]  = '{0, 0, 1, 32'h0C, 0,  4, 1, 1, 32'h00};
        vecs[6]  = '{0, 0, 1, 32'h10, 0,  4, 1, 1, 32'h00};
        // drain in order
        vecs[7]  = '{0, 0, 0, 32'h00, 1,  3, 0, 1, 32'h04};
        vecs[8]  = '{0, 0, 0, 32'h00, 1,  2, 0, 1, 32'h08};
        vecs[9]  = '{0, 0, 0, 32'h00, 1,  1, 0, 1, 32'h0C};
        vecs[10] = '{0, 0, 0, 32'h00, 1,  0, 0, 0, 32'h00};
        vecs[11] = '{0, 0, 0, 32'h00, 1,  0, 0, 0, 32'h00};
        // refill, then enqueue+dequeue while full
        vecs[12] = '{0, 0, 1, 32'h20, 0,  1, 0, 1, 32'h20};
        vecs[13] = '{0, 0, 1, 32'h24, 0,  2, 0, 1, 32'h20};
        vecs[14] = '{0, 0, 1, 32'h28, 0,  3, 0, 1, 32'h20};
        vecs[15] = '{0, 0, 1, 32'h2C, 0,  4, 1, 1, 32'h20};
        vecs[16] = '{0, 0, 1, 32'h30, 1,  3, 0, 1, 32'h24};
        vecs[17] = '{0, 0, 1, 32'h30, 0,  4, 1, 1, 32'h24};
        // flush at count 3 with enq and deq
        vecs[18] = '{0, 0, 0, 32'h00, 1,  3, 0, 1, 32'h28};
        vecs[19] = '{0, 1, 1, 32'h34, 1,  0, 0, 0, 32'h00};
        vecs[20] = '{0, 0, 1, 32'h40, 0,  1, 0, 1, 32'h40};
        vecs[21] = '{0, 0, 0, 32'h00, 1,  0, 0, 0, 32'h00};

        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_data = '0;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].ev, vecs[i].pc, vecs[i].dr);
            check($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_full,
                  vecs[i].e_valid, vecs[i].e_pc);
        end

        // Streaming from empty across pointer wrap: head lags input by one cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), 1'b1);
            check($sformatf("stream%0d", i), 1, 1'b0, 1'b1, 32'h100 + 32'(4 * i));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("stream_drain", 0, 1'b0, 1'b0, 32'h0);

        // Flush while full with deq_ready: empty next cycle.
        for (int i = 0; i < int'(DEPTH); i++)
            drive(1'b0, 1'b0, 1'b1, 32'h200 + 32'(4 * i), 1'b0);
        check("refull", 4, 1'b1, 1'b1, 32'h200);
        drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
        check("flush_full", 0, 1'b0, 1'b0, 32'h0);

        // Reset and flush together with enqueue: same as reset alone.
        drive(1'b0, 1'b0, 1'b1, 32'h400, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h404, 1'b0);
        check("pre_rst_flush", 2, 1'b0, 1'b1, 32'h400);
        drive(1'b1, 1'b1, 1'b1, 32'h408, 1'b1);
        check("rst_flush", 0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
        check("post_rst_enq", 1, 1'b0, 1'b1, 32'h500);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("post_rst_drain", 0, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
